ring_buffer_wr_arbiter: RTL and testbench

//   Shares the single write port of one ring_buffer between N producers.

---
 rtl/ring_buffer_wr_arbiter_pkg.sv | 43 ++++
 rtl/ring_buffer_wr_arbiter_rr_priority_pick.sv | 42 ++++
 rtl/ring_buffer_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_ring_buffer_wr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_buffer_wr_arbiter_pkg.sv
// Shared types and helpers for the ring-buffer write-port arbiter: FSM state encoding,
// width localparams for the default configuration and a reference round-robin pick.
package rb_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int ID_W          = $clog2(DEF_N_REQ);
  localparam int CNT_W         = $clog2(DEF_MAX_BURST + 1);
  localparam int RR_MAX_REQ    = 16;
  localparam int STAT_W        = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping at n; scanning downward lets the
  // closest candidate overwrite the farther ones.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [3:0] ptr,
                                       input int n);
    rr_pick_t res;
    int j;
    res = '0;
    for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (valid[j[3:0]]) begin
          res.found = 1'b1;
          res.idx   = j[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_buffer_wr_arbiter_rr_priority_pick.sv
// Round-robin winner selection: rotate the request vector so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_valid
);

  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  logic [W:0]   src;
  logic [W:0]   sum;
  logic [W-1:0] off;

  always_comb begin
    rot       = '0;
    src       = '0;
    sum       = '0;
    off       = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      src = {1'b0, ptr} + (W+1)'(i);
      if (src >= (W+1)'(N)) src = src - (W+1)'(N);
      rot[i] = valid[src[W-1:0]];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off       = W'(i);
        any_valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/ring_buffer_wr_arbiter.sv
// Shares one ring_buffer write port between N_REQ producers with round-robin packet-locked grants.
// Define RB_ARB_STATS_EN to add grant_cnt_o, one saturating 16-bit completed-grant counter per producer.
module ring_buffer_wr_arbiter
  import rb_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_last_i,
  input  logic [N_REQ*WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     enqueue_o,
  output logic [WIDTH-1:0]         data_o,
  input  logic                     full_i,
`ifdef RB_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0]  grant_cnt_o,
`endif
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o
);

  localparam int GNT_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [GNT_W-1:0]  grant_q;
  logic [GNT_W-1:0]  grant_nxt;
  logic [GNT_W-1:0]  rr_ptr;
  logic [GNT_W-1:0]  ptr_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] cnt_nxt;

  logic [GNT_W-1:0]  pick_idx;
  logic              pick_any;
  logic              sel_valid;
  logic              sel_last;
  logic [WIDTH-1:0]  sel_data;
  logic              xfer;
  logic              grant_done;

  rr_priority_pick #(
    .N (N_REQ)
  ) u_pick (
    .valid     (req_valid_i),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign sel_valid  = req_valid_i[grant_q];
  assign sel_last   = req_last_i[grant_q];
  assign sel_data   = req_data_i[int'(grant_q)*WIDTH +: WIDTH];

  // Ready is gated by full, so no beat is ever offered to a full buffer.
  assign busy_o     = (state == ACTIVE);
  assign xfer       = busy_o & sel_valid & ~full_i;
  assign grant_done = xfer & (sel_last | (beat_cnt == BEAT_W'(MAX_BURST - 1)));
  assign enqueue_o  = xfer;
  assign data_o     = busy_o ? sel_data : '0;
  assign grant_id_o = grant_q;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    ptr_nxt     = rr_ptr;
    cnt_nxt     = beat_cnt;
    req_ready_o = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        req_ready_o[grant_q] = ~full_i;
        if (xfer) cnt_nxt = beat_cnt + 1'b1;
        if (grant_done) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant_q == GNT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      rr_ptr   <= ptr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

`ifdef RB_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [N_REQ];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_REQ; k++) stat_cnt[k] <= '0;
    end else if (grant_done && (stat_cnt[grant_q] != {STAT_W{1'b1}})) begin
      stat_cnt[grant_q] <= stat_cnt[grant_q] + 1'b1;
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_stat
    assign grant_cnt_o[k*STAT_W +: STAT_W] = stat_cnt[k];
  end
`endif

endmodule

// File: tb/tb_ring_buffer_wr_arbiter.sv
// Scoreboard bench for ring_buffer_wr_arbiter with a behavioural 5-deep buffer model;
// define RB_ARB_STATS_EN to also check the grant counters.
module tb_ring_buffer_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 5;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   enqueue_o;
  logic [WIDTH-1:0]       data_o;
  logic                   full_i;
  logic [1:0]             grant_id_o;
  logic                   busy_o;
`ifdef RB_ARB_STATS_EN
  logic [N_REQ*16-1:0]    grant_cnt_o;
`endif

  ring_buffer_wr_arbiter #(
    .WIDTH     (WIDTH),
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .enqueue_o   (enqueue_o),
    .data_o      (data_o),
    .full_i      (full_i),
`ifdef RB_ARB_STATS_EN
    .grant_cnt_o (grant_cnt_o),
`endif
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] pq [N_REQ][$];
  logic [9:0] enq_exp[$];
  logic [7:0] deq_exp[$];
  logic [7:0] buf_q[$];
  int         deq_req_cnt  = 0;
  int         deq_done_cnt = 0;
  bit         deq_cont     = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic [7:0] d, input logic last);
    pq[k].push_back({last, d});
  endtask

  // Expected grant order is hand-computed by the caller, not derived from load order.
  task automatic expect_beat(input int k, input logic [7:0] d);
    enq_exp.push_back({2'(k), d});
    deq_exp.push_back(d);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"},  busy_o,      0);
    check_output({tag, "_enq"},   enqueue_o,   0);
    check_output({tag, "_ready"}, req_ready_o, 0);
    check_output({tag, "_data"},  data_o,      0);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    #1;
    check_idle_outputs("rst");
    check_output("rst_gid", grant_id_o, 0);
    for (int k = 0; k < N_REQ; k++) pq[k].delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_done(input string tag, input bit need_deq);
    int n;
    n = 0;
    while ((enq_exp.size() != 0 || (need_deq && deq_exp.size() != 0)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got enq_left=%0d deq_left=%0d want 0", tag,
               enq_exp.size(), deq_exp.size());
    end
  endtask

  // Producer and buffer model: handshakes sampled mid-cycle, state updated just after the edge.
  initial begin
    logic [3:0] fire;
    bit         enq;
    logic [7:0] enq_d;
    bit         do_deq;
    logic [7:0] got;
    logic [8:0] beat;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    full_i      = 1'b0;
    forever begin
      @(negedge clk);
      fire   = req_ready_o & req_valid_i;
      enq    = enqueue_o;
      enq_d  = data_o;
      do_deq = (deq_cont || deq_done_cnt < deq_req_cnt) && buf_q.size() > 0;
      @(posedge clk);
      #1;
      for (int k = 0; k < N_REQ; k++)
        if (fire[k] && pq[k].size() > 0) void'(pq[k].pop_front());
      if (enq) buf_q.push_back(enq_d);
      if (do_deq) begin
        if (deq_done_cnt < deq_req_cnt) deq_done_cnt++;
        got = buf_q.pop_front();
        if (deq_exp.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL deq_extra: got=%0h want none", got);
        end else begin
          check_output("deq_data", got, deq_exp.pop_front());
        end
      end
      full_i = (buf_q.size() >= DEPTH);
      for (int k = 0; k < N_REQ; k++) begin
        if (pq[k].size() > 0) begin
          beat = pq[k][0];
          req_valid_i[k]              = 1'b1;
          req_last_i[k]               = beat[8];
          req_data_i[k*WIDTH +: WIDTH] = beat[7:0];
        end else begin
          req_valid_i[k]              = 1'b0;
          req_last_i[k]               = 1'b0;
          req_data_i[k*WIDTH +: WIDTH] = '0;
        end
      end
    end
  end

  // Scoreboard monitor: every enqueue is matched against the next expected {grant, data}.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (enqueue_o) begin
        if (enq_exp.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL enq_extra: got gid=%0d data=%0h want none", grant_id_o, data_o);
        end else begin
          e = enq_exp.pop_front();
          check_output("enq_beat", {grant_id_o, data_o}, e);
        end
      end
      if (full_i) check_output("enq_while_full", enqueue_o, 0);
      check_output("ready_onehot", ($countones(req_ready_o) <= 1), 1);
    end
  end

  initial begin
    int n;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("por");
    check_output("por_gid", grant_id_o, 0);
    rstn = 1'b1;

    // Single producer 2 sends "abc": one bubble, then three back-to-back beats.
    deq_cont = 1'b1;
    @(posedge clk);
    #2;
    apply_stimulus(2, 8'h61, 1'b0);
    apply_stimulus(2, 8'h62, 1'b0);
    apply_stimulus(2, 8'h63, 1'b1);
    expect_beat(2, 8'h61);
    expect_beat(2, 8'h62);
    expect_beat(2, 8'h63);
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("s1_bubble");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("s1_enq", enqueue_o, 1);
      check_output("s1_gid", grant_id_o, 2);
      check_output("s1_ready", req_ready_o, 4'b0100);
    end
    @(negedge clk);
    check_output("s1_release", busy_o, 0);
    wait_done("s1", 1'b1);

    // rr_ptr now 3: producer 3 must beat producer 0, then the search wraps to 0.
    apply_stimulus(0, 8'h01, 1'b1);
    apply_stimulus(3, 8'h03, 1'b1);
    expect_beat(3, 8'h03);
    expect_beat(0, 8'h01);
    wait_done("s1_wrap", 1'b1);

    // All four valid, single-beat packets, producer 0 twice; buffer ends exactly full.
    @(negedge clk);
    reset_dut();
    deq_cont = 1'b0;
    apply_stimulus(0, 8'h61, 1'b1);
    apply_stimulus(0, 8'h65, 1'b1);
    apply_stimulus(1, 8'h62, 1'b1);
    apply_stimulus(2, 8'h63, 1'b1);
    apply_stimulus(3, 8'h64, 1'b1);
    expect_beat(0, 8'h61);
    expect_beat(1, 8'h62);
    expect_beat(2, 8'h63);
    expect_beat(3, 8'h64);
    expect_beat(0, 8'h65);
    wait_done("s2", 1'b0);
    repeat (2) @(negedge clk);
    check_output("s2_fill", buf_q.size(), 5);
    deq_cont = 1'b1;
    wait_done("s2_drain", 1'b1);

    // Producer 1 streams 10 beats with no last: bursts 4,4,2 interleaved with 0 and 3.
    @(negedge clk);
    reset_dut();
    apply_stimulus(0, 8'h40, 1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 8'h10 + 8'(i), 1'b0);
    apply_stimulus(3, 8'h33, 1'b1);
    apply_stimulus(3, 8'h34, 1'b1);
    expect_beat(0, 8'h40);
    for (int i = 0; i < 4; i++) expect_beat(1, 8'h10 + 8'(i));
    expect_beat(3, 8'h33);
    for (int i = 4; i < 8; i++) expect_beat(1, 8'h10 + 8'(i));
    expect_beat(3, 8'h34);
    expect_beat(1, 8'h18);
    expect_beat(1, 8'h19);
    wait_done("s3", 1'b1);
    repeat (3) @(negedge clk);
    check_output("s3_hold_busy", busy_o, 1);
    check_output("s3_hold_gid", grant_id_o, 1);
    check_output("s3_hold_enq", enqueue_o, 0);

    // Full buffer while producer 2 owns the grant; one dequeue admits exactly one beat.
    @(negedge clk);
    reset_dut();
    deq_cont = 1'b0;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(2, 8'h70 + 8'(i), (i == 6));
      expect_beat(2, 8'h70 + 8'(i));
    end
    n = 0;
    while (buf_q.size() < DEPTH && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_output("s4_filled", buf_q.size(), 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("s4_full_enq", enqueue_o, 0);
      check_output("s4_full_ready", req_ready_o, 0);
      check_output("s4_full_busy", busy_o, 1);
    end
    #2;
    deq_req_cnt++;
    repeat (4) @(negedge clk);
    check_output("s4_refill", buf_q.size(), 5);
    check_output("s4_one_beat", pq[2].size(), 1);
    check_output("s4_blocked", enqueue_o, 0);
    deq_cont = 1'b1;
    wait_done("s4", 1'b1);

    // Reset in the middle of producer 3's burst; afterwards the search restarts from 0.
    @(negedge clk);
    reset_dut();
    apply_stimulus(1, 8'hA1, 1'b1);
    apply_stimulus(1, 8'hA2, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(3, 8'hB0 + 8'(i), 1'b0);
    expect_beat(1, 8'hA1);
    expect_beat(3, 8'hB0);
    expect_beat(3, 8'hB1);
    expect_beat(1, 8'hA2);
    expect_beat(3, 8'hB2);
    expect_beat(3, 8'hB3);
    n = 0;
    while (pq[3].size() != 2 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_output("s5_mid_busy", busy_o, 1);
    rstn = 1'b0;
    #1;
    check_idle_outputs("s5_rst");
    check_output("s5_rst_gid", grant_id_o, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_done("s5", 1'b1);
    repeat (3) @(negedge clk);
    check_output("s5_hold_gid", grant_id_o, 3);
    check_output("s5_hold_busy", busy_o, 1);

    @(negedge clk);
    reset_dut();
`ifdef RB_ARB_STATS_EN
    // Two rounds of one packet per producer give two completed grants each.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N_REQ; k++) begin
        apply_stimulus(k, 8'hC0 + 8'(k), 1'b1);
        expect_beat(k, 8'hC0 + 8'(k));
      end
      wait_done("s6", 1'b1);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N_REQ; k++) check_output("s6_grant_cnt", grant_cnt_o[k*16 +: 16], 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
